// File: rtl/i2c_pkg.sv
// Shared types and defaults for the DDC/I2C receive-side conditioner.
// Bus-state encoding, default timing constants and small helpers.
package i2c_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_BUSY  = 2'd1,
        BUS_STUCK = 2'd2
    } bus_state_e;

    localparam int I2C_FILT_LEN_DEF = 8;
    localparam int I2C_TIMEOUT_DEF  = 3712500;
    localparam int I2C_TMO_W        = 24;

    typedef logic [I2C_TMO_W-1:0] tmo_cnt_t;

    // One-cycle event bundle produced alongside the filtered levels.
    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } i2c_evt_t;

    // Increment that sticks at the limit instead of wrapping.
    function automatic tmo_cnt_t sat_inc(input tmo_cnt_t v, input tmo_cnt_t lim);
        tmo_cnt_t r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + tmo_cnt_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus persistence filter for one open-drain line.
// Filter built only when I2C_GLITCH_FILTER_EN is defined; else one register stage.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILT_LEN = I2C_FILT_LEN_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic level_d_o
);

    logic [1:0] sync_q;
    logic       sync_lvl;
    logic       level_q;
    logic       level_d;

    assign sync_lvl = sync_q[1];

    // Metastability guard; idle bus is high so reload ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] LEN_C = CW'(FILT_LEN);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    // Follow the synchronised level only after FILT_LEN mismatching cycles.
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        level_d = level_q;
        cnt_d   = '0;
        if (sync_lvl != level_q) begin
            if (cnt_inc == LEN_C) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // Mismatch run-length register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_len;
    assign unused_len = ^FILT_LEN;

    // No filtering: one extra register stage, same as a length of one.
    always_comb begin
        level_d = sync_lvl;
    end
`endif

    // Filtered level register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o   = level_q;
    assign level_d_o = level_d;

endmodule

// File: rtl/i2c_bus_cond.sv
// DDC receive conditioner: filtered SCL/SDA, edge/START/STOP strobes, bus FSM.
// Optional spike filter enabled with `define I2C_GLITCH_FILTER_EN.
module i2c_bus_cond
    import i2c_pkg::*;
#(
    parameter int FILT_LEN    = I2C_FILT_LEN_DEF,
    parameter int TIMEOUT_CYC = I2C_TIMEOUT_DEF
) (
    input  logic i_local_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_f,
    output logic o_sda_f,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_busy,
    output logic o_timeout
);

    localparam tmo_cnt_t TMO_C = tmo_cnt_t'(TIMEOUT_CYC);

    logic       scl_q;
    logic       scl_d;
    logic       sda_q;
    logic       sda_d;

    i2c_evt_t   evt_d;
    i2c_evt_t   evt_q;

    bus_state_e state_q;
    bus_state_e state_d;
    tmo_cnt_t   tcnt_q;
    tmo_cnt_t   tcnt_d;
    logic       tmo_q;
    logic       tmo_d;

    i2c_line_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_scl_filt (
        .clk_i     (i_local_clk),
        .rst_ni    (i_rst_n),
        .line_i    (i_scl),
        .level_o   (scl_q),
        .level_d_o (scl_d)
    );

    i2c_line_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_sda_filt (
        .clk_i     (i_local_clk),
        .rst_ni    (i_rst_n),
        .line_i    (i_sda),
        .level_o   (sda_q),
        .level_d_o (sda_d)
    );

    // Events from current vs next filtered levels, so strobes align with the level.
    always_comb begin
        evt_d          = '0;
        evt_d.scl_rise = ~scl_q & scl_d;
        evt_d.scl_fall = scl_q & ~scl_d;
        evt_d.start    = scl_q & scl_d & sda_q & ~sda_d;
        evt_d.stop     = scl_q & scl_d & ~sda_q & sda_d;
    end

    // Strobe register.
    always_ff @(posedge i_local_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    // Bus ownership and stuck-SCL watchdog.
    always_comb begin
        state_d = state_q;
        tcnt_d  = '0;
        tmo_d   = 1'b0;
        unique case (state_q)
            BUS_IDLE: begin
                if (evt_d.start) begin
                    state_d = BUS_BUSY;
                end
            end
            BUS_BUSY: begin
                if (evt_d.start) begin
                    state_d = BUS_BUSY;
                end else if (evt_d.stop) begin
                    state_d = BUS_IDLE;
                end else if (!scl_q) begin
                    tcnt_d = sat_inc(tcnt_q, TMO_C);
                    if (tcnt_d == TMO_C) begin
                        state_d = BUS_STUCK;
                        tmo_d   = 1'b1;
                        tcnt_d  = '0;
                    end
                end
            end
            BUS_STUCK: begin
                if (evt_d.start) begin
                    state_d = BUS_BUSY;
                end else if (scl_q) begin
                    state_d = BUS_IDLE;
                end
            end
            default: begin
                state_d = BUS_IDLE;
            end
        endcase
    end

    // FSM state, timeout counter and timeout strobe registers.
    always_ff @(posedge i_local_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= BUS_IDLE;
            tcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign o_scl_f    = scl_q;
    assign o_sda_f    = sda_q;
    assign o_scl_rise = evt_q.scl_rise;
    assign o_scl_fall = evt_q.scl_fall;
    assign o_start    = evt_q.start;
    assign o_stop     = evt_q.stop;
    assign o_busy     = (state_q == BUS_BUSY);
    assign o_timeout  = tmo_q;

endmodule
